trace_event_counters: RTL

Performance-counter bank downstream of the core's registered trace outputs. It counts selected per-cycle trace events (stalls, issues, mispredicts, loads, stores) in live counters. On request it freezes a snapshot of all counters and streams it out one counter per beat over a valid/ready port, for the debug/host side. Live counting continues during readout.

---
 rtl/trace_event_counters.sv | 106 ++++++++++
 1 files changed

// File: rtl/trace_event_counters.sv
// Bank of live trace-event counters with a frozen snapshot streamed out one counter per beat.
// Optional feature macro TRACE_COUNTER_SATURATE_EN: counters saturate at all-ones instead of wrapping.
`timescale 1ns/1ps
module trace_event_counters #(
  parameter int NUM_EVENTS = 8,
  parameter int COUNTER_W  = 32,
  localparam int IDX_W     = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  snap_req,
  output logic                  rd_valid,
  output logic [IDX_W-1:0]      rd_index,
  output logic [COUNTER_W-1:0]  rd_data,
  input  logic                  rd_ready,
  output logic                  snap_done,
  output logic                  busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS - 1);

  state_t               state_q, state_d;
  logic [COUNTER_W-1:0] cnt_q  [NUM_EVENTS];
  logic [COUNTER_W-1:0] snap_q [NUM_EVENTS];
  logic [IDX_W-1:0]     idx_q;
  logic                 capture;
  logic                 beat_hs;
  logic                 last_hs;

  function automatic logic [COUNTER_W-1:0] next_count(input logic [COUNTER_W-1:0] c);
`ifdef TRACE_COUNTER_SATURATE_EN
    next_count = (&c) ? c : c + COUNTER_W'(1);
`else
    next_count = c + COUNTER_W'(1);
`endif
  endfunction

  // Live counters: clear takes priority over a same-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (clear)
          cnt_q[i] <= '0;
        else if (enable && events[i])
          cnt_q[i] <= next_count(cnt_q[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_done <= 1'b0;
      for (int i = 0; i < NUM_EVENTS; i++) snap_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      snap_done <= last_hs;
      if (capture) begin
        snap_q <= cnt_q;
        idx_q  <= '0;
      end else if (beat_hs) begin
        idx_q  <= last_hs ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Snapshot takes the registered counts, so same-cycle events and clears are excluded.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    beat_hs = 1'b0;
    last_hs = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (rd_ready) begin
          beat_hs = 1'b1;
          if (idx_q == LAST_IDX) begin
            last_hs = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_valid = (state_q == STREAM);
  assign busy     = (state_q != IDLE);
  assign rd_index = idx_q;
  assign rd_data  = snap_q[idx_q];

endmodule
